// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - memory-stage pipeline, data-memory and writeback signal bundle
// master is the controller's view; slave is the view of the pipeline/memory around it.
interface mem_stage_ctrl_if #(
   parameter int DW = 16,
   parameter int AW = 16,
   parameter int RW = 3
);
   logic          regwrM;
   logic [1:0]    memregM;
   logic          memwrM;
   logic [DW-1:0] aluoutM;
   logic [DW-1:0] writedataM;
   logic [DW-1:0] pcplusM;
   logic [RW-1:0] wregM;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   logic          stallM;
   logic          regwrW;
   logic [1:0]    memregW;
   logic [DW-1:0] resultW;
   logic [RW-1:0] wregW;
   logic          memerr;

   modport master (
      input  regwrM, memregM, memwrM, aluoutM, writedataM, pcplusM, wregM,
      input  mem_ack, mem_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output stallM, regwrW, memregW, resultW, wregW, memerr
   );

   modport slave (
      output regwrM, memregM, memwrM, aluoutM, writedataM, pcplusM, wregM,
      output mem_ack, mem_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  stallM, regwrW, memregW, resultW, wregW, memerr
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller with req/ack data-memory handshake and M->W register
// Stalls upstream while an access is outstanding; a missing ack aborts after TIMEOUT WAIT cycles.
module mem_stage_ctrl #(
   parameter int DW      = 16,
   parameter int AW      = 16,
   parameter int RW      = 3,
   parameter int TIMEOUT = 15
) (
   input  logic           CLK,
   input  logic           RSTn,
   mem_stage_ctrl_if.master bus
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e        state_q,     state_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   logic          abort_q,     abort_d;
   logic [DW-1:0] rdata_q,     rdata_d;
   logic          mem_req_q,   mem_req_d;
   logic          mem_we_q,    mem_we_d;
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          regwrW_q,    regwrW_d;
   logic [1:0]    memregW_q,   memregW_d;
   logic [DW-1:0] resultW_q,   resultW_d;
   logic [RW-1:0] wregW_q,     wregW_d;
   logic          memerr_q,    memerr_d;
   logic          stall;

   logic access;
   logic rw_conflict;
   logic timeout_hit;

   assign access      = bus.memwrM | (bus.memregM == 2'b01);
   assign rw_conflict = bus.memwrM & (bus.memregM == 2'b01);
   // Last permitted WAIT cycle: the counter started at 0 in the first WAIT cycle.
   assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      abort_d     = abort_q;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      regwrW_d    = regwrW_q;
      memregW_d   = memregW_q;
      resultW_d   = resultW_q;
      wregW_d     = wregW_q;
      memerr_d    = memerr_q;
      stall       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (access) begin
               stall       = 1'b1;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.memwrM;
               mem_addr_d  = bus.aluoutM[AW-1:0];
               mem_wdata_d = bus.writedataM;
               cnt_d       = '0;
               abort_d     = 1'b0;
               regwrW_d    = 1'b0;
               state_d     = WAIT;
            end else begin
               regwrW_d  = bus.regwrM;
               memregW_d = bus.memregM;
               wregW_d   = bus.wregM;
               resultW_d = (bus.memregM == 2'b10) ? bus.pcplusM : bus.aluoutM;
            end
         end

         WAIT: begin
            stall = 1'b1;
            cnt_d = cnt_q + CW'(1);
            // An ack on the final WAIT cycle still wins over the timeout.
            if (bus.mem_ack) begin
               rdata_d   = bus.mem_rdata;
               mem_req_d = 1'b0;
               state_d   = DONE;
            end else if (timeout_hit) begin
               mem_req_d = 1'b0;
               memerr_d  = 1'b1;
               abort_d   = 1'b1;
               state_d   = DONE;
            end
         end

         DONE: begin
            regwrW_d  = bus.regwrM & ~abort_q;
            memregW_d = rw_conflict ? 2'b00 : bus.memregM;
            resultW_d = (!mem_we_q && !abort_q) ? rdata_q : bus.aluoutM;
            wregW_d   = bus.wregM;
            state_d   = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         regwrW_q    <= 1'b0;
         memregW_q   <= 2'b00;
         resultW_q   <= '0;
         wregW_q     <= '0;
         memerr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         abort_q     <= abort_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         regwrW_q    <= regwrW_d;
         memregW_q   <= memregW_d;
         resultW_q   <= resultW_d;
         wregW_q     <= wregW_d;
         memerr_q    <= memerr_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.stallM    = stall;
   assign bus.regwrW    = regwrW_q;
   assign bus.memregW   = memregW_q;
   assign bus.resultW   = resultW_q;
   assign bus.wregW     = wregW_q;
   assign bus.memerr    = memerr_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl
// Instruction-level timeline model plus literal checkpoints identified by lit_id.
module tb_mem_stage_ctrl;
   localparam int DW      = 16;
   localparam int AW      = 16;
   localparam int RW      = 3;
   localparam int TIMEOUT = 15;

   logic CLK = 1'b0;
   logic RSTn;
   always #5 CLK = ~CLK;

   mem_stage_ctrl_if #(.DW(DW), .AW(AW), .RW(RW)) bus ();

   mem_stage_ctrl #(.DW(DW), .AW(AW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;
   int stall_cycles = 0, req_cycles = 0;
   int base_stall = 0, base_req = 0;
   bit check_en = 1'b0;
   int lit_id   = 0;

   logic          e_req, e_we, e_stall, e_regwr, e_err;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_result;
   logic [1:0]    e_memreg;
   logic [RW-1:0] e_wreg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         case (lit_id)
            1, 10: begin
               chk("rst_mem_req",   32'(bus.mem_req),   32'h0);
               chk("rst_mem_we",    32'(bus.mem_we),    32'h0);
               chk("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
               chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
               chk("rst_regwrW",    32'(bus.regwrW),    32'h0);
               chk("rst_memregW",   32'(bus.memregW),   32'h0);
               chk("rst_resultW",   32'(bus.resultW),   32'h0);
               chk("rst_wregW",     32'(bus.wregW),     32'h0);
               chk("rst_memerr",    32'(bus.memerr),    32'h0);
            end
            2: begin
               chk("alu_regwrW",  32'(bus.regwrW),  32'h1);
               chk("alu_resultW", 32'(bus.resultW), 32'h1234);
               chk("alu_wregW",   32'(bus.wregW),   32'h5);
               chk("alu_stalls",  32'(stall_cycles - base_stall), 32'd0);
            end
            3: begin
               chk("ld_resultW", 32'(bus.resultW), 32'hBEEF);
               chk("ld_memregW", 32'(bus.memregW), 32'h1);
               chk("ld_regwrW",  32'(bus.regwrW),  32'h1);
               chk("ld_stalls",  32'(stall_cycles - base_stall), 32'd4);
               chk("ld_reqs",    32'(req_cycles - base_req),     32'd3);
            end
            4: begin
               chk("st_mem_we",    32'(bus.mem_we),    32'h1);
               chk("st_mem_wdata", 32'(bus.mem_wdata), 32'hA5A5);
               chk("st_regwrW",    32'(bus.regwrW),    32'h0);
               chk("st_stalls",    32'(stall_cycles - base_stall), 32'd2);
            end
            5: begin
               chk("to_reqs",   32'(req_cycles - base_req),     32'd15);
               chk("to_stalls", 32'(stall_cycles - base_stall), 32'd16);
               chk("to_memerr", 32'(bus.memerr), 32'h1);
               chk("to_regwrW", 32'(bus.regwrW), 32'h0);
            end
            6: begin
               chk("post_to_regwrW",  32'(bus.regwrW),  32'h1);
               chk("post_to_resultW", 32'(bus.resultW), 32'h0077);
               chk("post_to_memerr",  32'(bus.memerr),  32'h1);
            end
            7: begin
               chk("cf_mem_we",   32'(bus.mem_we),   32'h1);
               chk("cf_memregW",  32'(bus.memregW),  32'h0);
               chk("cf_resultW",  32'(bus.resultW),  32'h0008);
            end
            8: begin
               chk("pc_memregW", 32'(bus.memregW), 32'h2);
               chk("pc_resultW", 32'(bus.resultW), 32'h0100);
            end
            11: begin
               chk("after_rst_regwrW",  32'(bus.regwrW),  32'h1);
               chk("after_rst_resultW", 32'(bus.resultW), 32'h4321);
               chk("after_rst_memerr",  32'(bus.memerr),  32'h0);
            end
            default: ;
         endcase
         if (lit_id != 0) begin
            base_stall = stall_cycles;
            base_req   = req_cycles;
         end
         if (check_en) begin
            chk("mem_req",   32'(bus.mem_req),   32'(e_req));
            chk("mem_we",    32'(bus.mem_we),    32'(e_we));
            chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
            chk("stallM",    32'(bus.stallM),    32'(e_stall));
            chk("regwrW",    32'(bus.regwrW),    32'(e_regwr));
            chk("memregW",   32'(bus.memregW),   32'(e_memreg));
            chk("resultW",   32'(bus.resultW),   32'(e_result));
            chk("wregW",     32'(bus.wregW),     32'(e_wreg));
            chk("memerr",    32'(bus.memerr),    32'(e_err));
         end
         if (bus.stallM)  stall_cycles++;
         if (bus.mem_req) req_cycles++;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_model();
      e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_stall = 0;
      e_regwr = 0; e_memreg = 2'b00; e_result = '0; e_wreg = '0; e_err = 0;
   endtask

   task automatic set_inputs(input logic rw, input logic [1:0] mr, input logic mw,
                             input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                             input logic [DW-1:0] pc, input logic [RW-1:0] wr);
      bus.regwrM = rw; bus.memregM = mr; bus.memwrM = mw;
      bus.aluoutM = alu; bus.writedataM = wd; bus.pcplusM = pc; bus.wregM = wr;
   endtask

   // ack_lat: WAIT cycle (1-based) carrying mem_ack; 0 means the memory never answers.
   task automatic do_op(input logic rw, input logic [1:0] mr, input logic mw,
                        input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                        input logic [DW-1:0] pc, input logic [RW-1:0] wr,
                        input int ack_lat, input logic [DW-1:0] rd, input int lit);
      logic acc;
      logic aborted;
      set_inputs(rw, mr, mw, alu, wd, pc, wr);
      lit_id = lit;
      acc = mw || (mr == 2'b01);
      if (!acc) begin
         bus.mem_ack = 1'b0; bus.mem_rdata = 16'h5555; e_stall = 1'b0;
         step();
         lit_id = 0;
         e_regwr = rw; e_memreg = mr; e_wreg = wr;
         e_result = (mr == 2'b10) ? pc : alu;
      end else begin
         bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD; e_stall = 1'b1;
         step();
         lit_id = 0;
         e_req = 1'b1; e_we = mw; e_addr = alu[AW-1:0]; e_wdata = wd; e_regwr = 1'b0;
         aborted = 1'b1;
         for (int k = 1; k <= TIMEOUT; k++) begin
            bus.mem_ack   = (k == ack_lat);
            bus.mem_rdata = (k == ack_lat) ? rd : 16'h5A5A;
            e_stall = 1'b1;
            step();
            if (k == ack_lat) begin
               e_req = 1'b0; aborted = 1'b0;
               break;
            end
            if (k == TIMEOUT) begin
               e_req = 1'b0; e_err = 1'b1;
            end
         end
         bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD; e_stall = 1'b0;
         step();
         bus.mem_ack = 1'b0;
         e_regwr  = aborted ? 1'b0 : rw;
         e_memreg = (mw && mr == 2'b01) ? 2'b00 : mr;
         e_result = (!mw && !aborted) ? rd : alu;
         e_wreg   = wr;
      end
   endtask

   task automatic nop(input int lit);
      do_op(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0, 16'h0, lit);
   endtask

   initial begin
      RSTn = 1'b0;
      set_inputs(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
      bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      clear_model();
      step();
      lit_id = 1;
      step();
      lit_id = 0;
      RSTn = 1'b1;
      check_en = 1'b1;
      step();

      do_op(1'b1, 2'b00, 1'b0, 16'h1234, 16'h0, 16'h0, 3'd5, 0, 16'h0, 9);
      nop(2);
      do_op(1'b1, 2'b01, 1'b0, 16'h0040, 16'h0, 16'h0, 3'd6, 3, 16'hBEEF, 0);
      nop(3);
      do_op(1'b0, 2'b00, 1'b1, 16'h0020, 16'hA5A5, 16'h0, 3'd1, 1, 16'h0, 0);
      nop(4);
      do_op(1'b1, 2'b01, 1'b0, 16'h0044, 16'h0, 16'h0, 3'd2, 0, 16'h0, 0);
      nop(5);
      do_op(1'b1, 2'b00, 1'b0, 16'h0077, 16'h0, 16'h0, 3'd3, 0, 16'h0, 0);
      nop(6);
      do_op(1'b1, 2'b01, 1'b1, 16'h0008, 16'h1111, 16'h0, 3'd4, 2, 16'hCAFE, 0);
      nop(7);
      do_op(1'b1, 2'b10, 1'b0, 16'h0999, 16'h0, 16'h0100, 3'd7, 0, 16'h0, 0);
      nop(8);
      do_op(1'b1, 2'b01, 1'b0, 16'h0050, 16'h0, 16'h0, 3'd1, TIMEOUT, 16'h7E57, 0);
      nop(0);

      // Load left hanging in WAIT, then reset asserted between clock edges.
      set_inputs(1'b1, 2'b01, 1'b0, 16'h0300, 16'h0, 16'h0, 3'd2);
      bus.mem_ack = 1'b0; e_stall = 1'b1;
      step();
      e_req = 1'b1; e_we = 1'b0; e_addr = 16'h0300; e_wdata = 16'h0; e_regwr = 1'b0;
      step();
      step();
      check_en = 1'b0;
      RSTn = 1'b0;
      lit_id = 10;
      @(negedge CLK);
      #1;
      lit_id = 0;
      set_inputs(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
      clear_model();
      step();
      RSTn = 1'b1;
      check_en = 1'b1;
      do_op(1'b1, 2'b00, 1'b0, 16'h4321, 16'h0, 16'h0, 3'd6, 0, 16'h0, 0);
      nop(11);
      nop(0);

      @(negedge CLK);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage controller and M->W pipeline register. It consumes the control bundle delivered to the memory stage (regwrM, memregM, memwrM) together with the datapath values for that stage. It runs a req/ack handshake with a variable-latency data memory and stalls the pipeline until the access completes. It then pushes the writeback control and result to the writeback stage.

Parameters:
DW, 16, datapath/data-memory word width
AW, 16, data-memory address width (taken from aluoutM[AW-1:0])
RW, 3, destination register index width
TIMEOUT, 15, max WAIT cycles before abort (must be >= 1)

Ports:
CLK  in  1  clock, all state updates on rising edge
RSTn  in  1  asynchronous, active-low reset
regwrM  in  1  register-file write enable for the instruction in M
memregM  in  2  writeback source: 00 ALU, 01 memory read, 10 pcplus, 11 ALU
memwrM  in  1  data-memory write request
aluoutM  in  DW  ALU result / memory address
writedataM  in  DW  store data
pcplusM  in  DW  link value
wregM  in  RW  destination register
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write, 0 = read, registered
mem_addr  out  AW  registered address
mem_wdata  out  DW  registered store data
mem_ack  in  1  memory completion, single-cycle pulse
mem_rdata  in  DW  read data, valid with mem_ack
stallM  out  1  hold F/D/E/M stages, combinational
regwrW  out  1  writeback enable
memregW  out  2  writeback source, passed through
resultW  out  DW  selected writeback value
wregW  out  RW  writeback destination
memerr  out  1  sticky timeout flag

Behaviour:
- Reset (RSTn=0, asynchronous): state=IDLE. mem_req, mem_we, mem_addr, mem_wdata, regwrW, memregW, resultW, wregW, memerr and the timeout counter all clear to 0. A reset during WAIT drops mem_req immediately; the in-flight access is abandoned.
- access = memwrM | (memregM==01). If memwrM and memregM==01 are both set, only the write is performed. memregW is forced to 00 and resultW = aluoutM.
- FSM states: IDLE, WAIT, DONE.
- IDLE, access=0:
  - stallM=0.
  - W register loads each edge: regwrW=regwrM, memregW=memregM, wregW=wregM.
  - resultW = pcplusM if memregM==10, else aluoutM.
- IDLE, access=1:
  - stallM=1 combinationally in the same cycle.
  - At the edge: mem_req<=1, mem_we<=memwrM, mem_addr<=aluoutM[AW-1:0], mem_wdata<=writedataM.
  - Counter<=0, state->WAIT, W loads a bubble (regwrW<=0).
- WAIT:
  - stallM=1. Upstream holds the M inputs stable while stallM=1.
  - mem_req and the registered address, data and we are held constant.
  - Counter increments each cycle. W holds the bubble (regwrW=0).
- WAIT, mem_ack=1: capture mem_rdata, mem_req<=0, state->DONE. An ack in the same cycle the counter reaches TIMEOUT counts as success.
- WAIT, counter==TIMEOUT with no ack: mem_req<=0, memerr<=1 (sticky until reset), state->DONE with the abort flag set.
- DONE:
  - stallM=0. At the edge W loads the M instruction: resultW = captured rdata for a read, aluoutM for a write.
  - regwrW=regwrM, except regwrW<=0 if the access aborted.
  - state->IDLE. The next instruction is evaluated from IDLE in the following cycle, with no back-to-back access bypass.
- Timing: minimum stall is 2 cycles (detect cycle plus a one-cycle WAIT with immediate ack). The result appears on W at the end of the DONE cycle.
- mem_ack is ignored in IDLE and DONE. mem_req never asserts in the same cycle as detection, because it is registered.

Test Plan:
- Reset mid-WAIT: read issued, RSTn pulsed low before ack -> mem_req=0 asynchronously, all outputs 0, memerr=0, state IDLE.
- ALU op: regwrM=1, memregM=00, aluoutM=0x1234, wregM=5 -> stallM never 1; next edge regwrW=1, resultW=0x1234, wregW=5.
- Load, ack after 3 WAIT cycles, aluoutM=0x0040, mem_rdata=0xBEEF:
  - mem_req=1, mem_we=0, mem_addr=0x0040 for 3 cycles.
  - stallM=1 for 4 cycles.
  - Then resultW=0xBEEF, memregW=01, regwrW=1.
- Store, memwrM=1, writedataM=0xA5A5, regwrM=0, immediate ack -> mem_we=1, mem_wdata=0xA5A5, stallM=1 for exactly 2 cycles, regwrW=0.
- Load with mem_ack never asserted, TIMEOUT=15 -> mem_req drops after 15 WAIT cycles, memerr=1 and stays 1, regwrW=0; a following ALU op still writes back normally.
- memwrM=1 with memregM=01, aluoutM=0x0008 -> mem_we=1, memregW=00, resultW=0x0008.
